// File: rtl/quad_compare_32.sv
// quad_compare_32: registered four-operand unsigned magnitude comparator.
// Finds the largest and smallest of lanes a(0), b(1), c(2), d(3) and reports
// each in two forms: a one-hot flag with ties going to the lowest lane index,
// and an all-tied flag vector marking every lane equal to the extreme.
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   in_valid    operands a..d are captured on the rising edge when high
//   a, b, c, d  WIDTH-bit unsigned operands (lanes 0..3)
//   out_valid   high for the one cycle after a valid capture
//   max_onehot  single largest lane, lowest index wins ties
//   min_onehot  single smallest lane, lowest index wins ties
//   max_all     every lane equal to the maximum
//   min_all     every lane equal to the minimum
module quad_compare_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic [3:0]       max_onehot,
  output logic [3:0]       min_onehot,
  output logic [3:0]       max_all,
  output logic [3:0]       min_all
);

  localparam int unsigned LANES = 4;

  // Six pairwise unsigned comparisons
  logic gt_ab, gt_ac, gt_ad, gt_bc, gt_bd, gt_cd;
  logic eq_ab, eq_ac, eq_ad, eq_bc, eq_bd, eq_cd;
  logic ge_ab, ge_ac, ge_ad, ge_bc, ge_bd, ge_cd;

  logic [LANES-1:0] max_all_c;
  logic [LANES-1:0] min_all_c;
  logic [LANES-1:0] max_onehot_c;
  logic [LANES-1:0] min_onehot_c;

  always_comb begin
    gt_ab = (a > b);
    gt_ac = (a > c);
    gt_ad = (a > d);
    gt_bc = (b > c);
    gt_bd = (b > d);
    gt_cd = (c > d);

    eq_ab = (a == b);
    eq_ac = (a == c);
    eq_ad = (a == d);
    eq_bc = (b == c);
    eq_bd = (b == d);
    eq_cd = (c == d);

    ge_ab = gt_ab | eq_ab;
    ge_ac = gt_ac | eq_ac;
    ge_ad = gt_ad | eq_ad;
    ge_bc = gt_bc | eq_bc;
    ge_bd = gt_bd | eq_bd;
    ge_cd = gt_cd | eq_cd;
  end

  // Lane is a maximum when >= every other lane; y >= x is expressed as ~(x > y)
  always_comb begin
    max_all_c    = '0;
    max_all_c[0] = ge_ab  & ge_ac  & ge_ad;
    max_all_c[1] = ~gt_ab & ge_bc  & ge_bd;
    max_all_c[2] = ~gt_ac & ~gt_bc & ge_cd;
    max_all_c[3] = ~gt_ad & ~gt_bd & ~gt_cd;
  end

  // Lane is a minimum when <= every other lane
  always_comb begin
    min_all_c    = '0;
    min_all_c[0] = ~gt_ab & ~gt_ac & ~gt_ad;
    min_all_c[1] = ge_ab  & ~gt_bc & ~gt_bd;
    min_all_c[2] = ge_ac  & ge_bc  & ~gt_cd;
    min_all_c[3] = ge_ad  & ge_bd  & ge_cd;
  end

  // Lowest-index-wins tie resolution: isolate the lowest set bit
  always_comb begin
    max_onehot_c    = '0;
    max_onehot_c[0] = max_all_c[0];
    max_onehot_c[1] = max_all_c[1] & ~max_all_c[0];
    max_onehot_c[2] = max_all_c[2] & ~(|max_all_c[1:0]);
    max_onehot_c[3] = max_all_c[3] & ~(|max_all_c[2:0]);

    min_onehot_c    = '0;
    min_onehot_c[0] = min_all_c[0];
    min_onehot_c[1] = min_all_c[1] & ~min_all_c[0];
    min_onehot_c[2] = min_all_c[2] & ~(|min_all_c[1:0]);
    min_onehot_c[3] = min_all_c[3] & ~(|min_all_c[2:0]);
  end

  // Output registers; flags hold their last result when no operands arrive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      max_onehot <= '0;
      min_onehot <= '0;
      max_all    <= '0;
      min_all    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        max_onehot <= max_onehot_c;
        min_onehot <= min_onehot_c;
        max_all    <= max_all_c;
        min_all    <= min_all_c;
      end
    end
  end

endmodule

// File: tb/tb_quad_compare_32.sv
// Directed-vector bench for quad_compare_32: reset, rotation of distinct
// values, ties, all-equal, unsigned extremes, hold and mid-stream reset.
module tb_quad_compare_32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a, b, c, d;
  logic        out_valid;
  logic [3:0]  max_onehot, min_onehot, max_all, min_all;

  int n_cmp = 0;
  int n_err = 0;

  quad_compare_32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .out_valid  (out_valid),
    .max_onehot (max_onehot),
    .min_onehot (min_onehot),
    .max_all    (max_all),
    .min_all    (min_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one input set, take a rising edge, settle 1 time unit after it.
  task automatic drive(input logic v, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] vc, input logic [31:0] vd);
    in_valid = v;
    a = va; b = vb; c = vc; d = vd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, max_onehot, min_onehot, max_all, min_all} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_async: got %b %b %b %b %b, want all zero",
               out_valid, max_onehot, min_onehot, max_all, min_all);
    end
    drive(1'b1, 32'd3, 32'd2, 32'd1, 32'd0);
    n_cmp++;
    if ({out_valid, max_onehot, min_onehot, max_all, min_all} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_hold: got %b %b %b %b %b, want all zero",
               out_valid, max_onehot, min_onehot, max_all, min_all);
    end
    rst = 1'b0;
  endtask

  task automatic test_rotation;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vc [4];
    logic [31:0] vd [4];
    logic [3:0]  exp_max [4];
    logic [3:0]  exp_min [4];
    va = '{32'd10, 32'd9,  32'd5,  32'd1};
    vb = '{32'd9,  32'd5,  32'd1,  32'd10};
    vc = '{32'd5,  32'd1,  32'd10, 32'd9};
    vd = '{32'd1,  32'd10, 32'd9,  32'd5};
    exp_max = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};
    exp_min = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, va[i], vb[i], vc[i], vd[i]);
      n_cmp++;
      if ({out_valid, max_onehot, min_onehot} !== {1'b1, exp_max[i], exp_min[i]}) begin
        n_err++;
        $display("FAIL rotation_%0d onehot: got v=%b max=%b min=%b, want v=1 max=%b min=%b",
                 i, out_valid, max_onehot, min_onehot, exp_max[i], exp_min[i]);
      end
      n_cmp++;
      if ({max_all, min_all} !== {exp_max[i], exp_min[i]}) begin
        n_err++;
        $display("FAIL rotation_%0d all: got max=%b min=%b, want max=%b min=%b",
                 i, max_all, min_all, exp_max[i], exp_min[i]);
      end
    end
  endtask

  task automatic test_distinct;
    drive(1'b1, 32'd525, 32'd12, 32'd41, 32'd31);
    n_cmp++;
    if ({out_valid, max_onehot, max_all, min_onehot, min_all} !== {1'b1, 4'b0001, 4'b0001, 4'b0010, 4'b0010}) begin
      n_err++;
      $display("FAIL distinct: got v=%b mo=%b ma=%b no=%b na=%b, want 1 0001 0001 0010 0010",
               out_valid, max_onehot, max_all, min_onehot, min_all);
    end
  endtask

  // Flags must hold across an in_valid=0 edge while out_valid drops.
  task automatic test_hold;
    drive(1'b0, 32'd0, 32'd1, 32'd2, 32'd3);
    n_cmp++;
    if ({out_valid, max_onehot, max_all, min_onehot, min_all} !== {1'b0, 4'b0001, 4'b0001, 4'b0010, 4'b0010}) begin
      n_err++;
      $display("FAIL hold: got v=%b mo=%b ma=%b no=%b na=%b, want 0 0001 0001 0010 0010",
               out_valid, max_onehot, max_all, min_onehot, min_all);
    end
  endtask

  task automatic test_tie_max;
    drive(1'b1, 32'd525, 32'd525, 32'd41, 32'd10);
    n_cmp++;
    if ({max_onehot, max_all} !== {4'b0001, 4'b0011}) begin
      n_err++;
      $display("FAIL tie_max: got onehot=%b all=%b, want 0001 0011", max_onehot, max_all);
    end
    n_cmp++;
    if ({min_onehot, min_all} !== {4'b1000, 4'b1000}) begin
      n_err++;
      $display("FAIL tie_max_min: got onehot=%b all=%b, want 1000 1000", min_onehot, min_all);
    end
  endtask

  task automatic test_tie_min;
    drive(1'b1, 32'd50, 32'd3, 32'd99, 32'd3);
    n_cmp++;
    if ({max_onehot, max_all, min_onehot, min_all} !== {4'b0100, 4'b0100, 4'b0010, 4'b1010}) begin
      n_err++;
      $display("FAIL tie_min: got mo=%b ma=%b no=%b na=%b, want 0100 0100 0010 1010",
               max_onehot, max_all, min_onehot, min_all);
    end
  endtask

  task automatic test_all_equal;
    drive(1'b1, 32'd7, 32'd7, 32'd7, 32'd7);
    n_cmp++;
    if ({max_all, min_all} !== {4'b1111, 4'b1111}) begin
      n_err++;
      $display("FAIL all_equal_all: got max=%b min=%b, want 1111 1111", max_all, min_all);
    end
    n_cmp++;
    if ({max_onehot, min_onehot} !== {4'b0001, 4'b0001}) begin
      n_err++;
      $display("FAIL all_equal_onehot: got max=%b min=%b, want 0001 0001", max_onehot, min_onehot);
    end
  endtask

  task automatic test_extremes;
    drive(1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
    n_cmp++;
    if ({max_all, max_onehot} !== {4'b1010, 4'b0010}) begin
      n_err++;
      $display("FAIL extremes_max: got all=%b onehot=%b, want 1010 0010", max_all, max_onehot);
    end
    n_cmp++;
    if ({min_all, min_onehot} !== {4'b0101, 4'b0001}) begin
      n_err++;
      $display("FAIL extremes_min: got all=%b onehot=%b, want 0101 0001", min_all, min_onehot);
    end
    // MSB-set operand against a small one must not compare as negative
    drive(1'b1, 32'd1, 32'd2, 32'h8000_0000, 32'd0);
    n_cmp++;
    if ({max_onehot, min_onehot} !== {4'b0100, 4'b1000}) begin
      n_err++;
      $display("FAIL extremes_msb: got max=%b min=%b, want 0100 1000", max_onehot, min_onehot);
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 32'd4, 32'd8, 32'd2, 32'd6);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, max_onehot, min_onehot, max_all, min_all} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_mid_async: got %b %b %b %b %b, want all zero",
               out_valid, max_onehot, min_onehot, max_all, min_all);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'd9, 32'd1, 32'd1, 32'd1);
    n_cmp++;
    if ({out_valid, max_onehot, min_onehot, max_all, min_all} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_release_idle: got %b %b %b %b %b, want all zero",
               out_valid, max_onehot, min_onehot, max_all, min_all);
    end
    drive(1'b1, 32'd4, 32'd8, 32'd2, 32'd6);
    n_cmp++;
    if ({out_valid, max_onehot, min_onehot, max_all, min_all} !== {1'b1, 4'b0010, 4'b0100, 4'b0010, 4'b0100}) begin
      n_err++;
      $display("FAIL reset_first_capture: got v=%b mo=%b no=%b ma=%b na=%b, want 1 0010 0100 0010 0100",
               out_valid, max_onehot, min_onehot, max_all, min_all);
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    n_cmp++;
    if ({out_valid, max_onehot, min_onehot} !== {1'b0, 4'b0010, 4'b0100}) begin
      n_err++;
      $display("FAIL reset_pulse_end: got v=%b mo=%b no=%b, want 0 0010 0100",
               out_valid, max_onehot, min_onehot);
    end
  endtask

  initial begin
    in_valid = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    test_reset();
    test_rotation();
    test_distinct();
    test_hold();
    test_tie_max();
    test_tie_min();
    test_all_equal();
    test_extremes();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
